// File: rtl/dreg_bank_shift.sv
`default_nettype none
// ============================================================================
//  Module   : dreg_bank_shift
//  Purpose  : CH x W clocked register bank with masked parallel load and
//             word-wide shift/rotate; optional per-channel parity (PARITY_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module dreg_bank_shift #(
    parameter int           W         = 4,
    parameter int           CH        = 4,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [CH-1:0]   ld_mask,
    input  logic [CH*W-1:0] d,
    input  logic [W-1:0]    sin,
    output logic [CH*W-1:0] q,
    output logic [W-1:0]    sout,
    output logic            upd
`ifdef PARITY_EN
    ,
    output logic [CH-1:0]   par
`endif
);

    localparam logic [1:0] c_mode_hold   = 2'b00;
    localparam logic [1:0] c_mode_load   = 2'b01;
    localparam logic [1:0] c_mode_shift  = 2'b10;
    localparam logic [1:0] c_mode_rotate = 2'b11;

    logic [W-1:0] r_ch   [CH];
    logic [W-1:0] w_next [CH];
    logic         w_wr;
    logic         r_upd;

    always_comb begin
        w_wr = 1'b0;
        for (int i = 0; i < CH; i++) begin
            w_next[i] = r_ch[i];
        end
        if (en) begin
            case (mode)
                c_mode_hold: begin
                    w_wr = 1'b0;
                end
                c_mode_load: begin
                    w_wr = |ld_mask;
                    for (int i = 0; i < CH; i++) begin
                        if (ld_mask[i]) begin
                            w_next[i] = d[i*W +: W];
                        end
                    end
                end
                c_mode_shift: begin
                    w_wr      = 1'b1;
                    w_next[0] = sin;
                    for (int i = 1; i < CH; i++) begin
                        w_next[i] = r_ch[i-1];
                    end
                end
                c_mode_rotate: begin
                    // With CH=1 this rewrites channel 0 with itself.
                    w_wr      = 1'b1;
                    w_next[0] = r_ch[CH-1];
                    for (int i = 1; i < CH; i++) begin
                        w_next[i] = r_ch[i-1];
                    end
                end
                default: begin
                    w_wr = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_ch[i] <= RESET_VAL;
            end
            r_upd <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_ch[i] <= w_next[i];
            end
            r_upd <= w_wr;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_q
        assign q[gi*W +: W] = r_ch[gi];
    end

    assign sout = r_ch[CH-1];
    assign upd  = r_upd;

`ifdef PARITY_EN
    logic [CH-1:0] r_par;

    // Parity is taken from the next-state value so it lands on the same edge as the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= {CH{^RESET_VAL}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_par[i] <= ^w_next[i];
            end
        end
    end

    assign par = r_par;
`endif

endmodule
`default_nettype wire
